// File: rtl/mem_port_arbiter_if.sv
// Bus bundles for the memory port arbiter: one requester-side bundle (used for
// both the CPU and the host) and one memory-device-side bundle.
interface mem_req_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface mem_dev_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between the stack CPU
// and the host loader, with ownership lock and bounded-wait pre-emption.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    mem_req_if.slave  cpu,
    mem_req_if.slave  host,
    mem_dev_if.master mem
);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_HOST} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state;
    state_t            next_state;
    logic              last_host;
    logic [7:0]        wait_cnt;
    logic              tag_valid;
    logic              tag_host;

    logic              owner_req;
    logic              owner_we;
    logic              owner_lock;
    logic              other_req;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;
    state_t            other_own;

    always_comb begin
        owner_req   = 1'b0;
        owner_we    = 1'b0;
        owner_lock  = 1'b0;
        other_req   = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        other_own   = IDLE;
        case (state)
            OWN_CPU: begin
                owner_req   = cpu.req;
                owner_we    = cpu.we;
                owner_lock  = cpu.lock;
                other_req   = host.req;
                owner_addr  = cpu.addr;
                owner_wdata = cpu.wdata;
                other_own   = OWN_HOST;
            end
            OWN_HOST: begin
                owner_req   = host.req;
                owner_we    = host.we;
                owner_lock  = host.lock;
                other_req   = cpu.req;
                owner_addr  = host.addr;
                owner_wdata = host.wdata;
                other_own   = OWN_CPU;
            end
            default: ;
        endcase
    end

    assign mem.en    = owner_req;
    assign mem.we    = owner_req & owner_we;
    assign mem.addr  = owner_req ? owner_addr : '0;
    assign mem.wdata = owner_req ? owner_wdata : '0;

    // An unlocked owner keeps the port while it requests, until the other side
    // has waited its full budget; a lock overrides both release and pre-emption.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu.req && host.req)
                    next_state = last_host ? OWN_CPU : OWN_HOST;
                else if (cpu.req)
                    next_state = OWN_CPU;
                else if (host.req)
                    next_state = OWN_HOST;
            end
            OWN_CPU, OWN_HOST: begin
                if (!owner_lock) begin
                    if (!owner_req)
                        next_state = other_req ? other_own : IDLE;
                    else if (other_req && (wait_cnt == WAIT_LAST))
                        next_state = other_own;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_host <= 1'b1;
            wait_cnt  <= 8'd0;
            tag_valid <= 1'b0;
            tag_host  <= 1'b0;
        end else begin
            state     <= next_state;
            tag_valid <= mem.en & ~mem.we;
            tag_host  <= (state == OWN_HOST);
            if (next_state != state) begin
                wait_cnt <= 8'd0;
                if (next_state == OWN_CPU)
                    last_host <= 1'b0;
                else if (next_state == OWN_HOST)
                    last_host <= 1'b1;
            end else if ((state != IDLE) && other_req) begin
                if (wait_cnt != WAIT_LAST)
                    wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    assign cpu.gnt     = (state == OWN_CPU);
    assign host.gnt    = (state == OWN_HOST);
    assign cpu.rvalid  = tag_valid & ~tag_host;
    assign host.rvalid = tag_valid & tag_host;
    assign cpu.rdata   = cpu.rvalid ? mem.rdata : '0;
    assign host.rdata  = host.rvalid ? mem.rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 8-bit external memory port between two requesters: the stack CPU and a host loader/debug port.
- Sits between the CPU core's memory-side signals and the memory device.
- Ownership changes round-robin. A requester can lock ownership for multi-cycle instruction sequences such as push-memory or store.
- A bounded-wait counter prevents either side starving the other.

Parameters:
- ADDR_W, 8, width of the address on both requesters and on the memory.
- DATA_W, 8, width of the data on both requesters and on the memory.
- MAX_WAIT, 4, cycles a waiting requester is held off before a non-locked owner is pre-empted. Legal range is 1..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests a memory access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_lock  in  1  CPU keeps ownership after the current access.
- cpu_addr  in  ADDR_W  CPU access address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU owns the port.
- cpu_rvalid  out  1  CPU read data is valid.
- cpu_rdata  out  DATA_W  CPU read data.
- host_req, host_we, host_lock, host_addr, host_wdata  in  same widths as the CPU equivalents  host equivalents.
- host_gnt, host_rvalid, host_rdata  out  same widths as the CPU equivalents  host equivalents.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, registered in the memory, valid one cycle after a read strobe.

Behaviour:
- State machine states:
  - IDLE: no owner.
  - OWN_CPU: CPU owns the port.
  - OWN_HOST: host owns the port.
- Grants are Moore outputs: cpu_gnt = (state == OWN_CPU), host_gnt = (state == OWN_HOST).
- Access rule: a combinational pass-through from the owner.
  - mem_en = owner_req.
  - mem_we = owner_req & owner_we.
  - mem_addr and mem_wdata are the owner's address and data.
  - When there is no owner or no request: all mem outputs are 0.
  - A requester's access completes in a cycle where its gnt and req are both 1. Throughput is one access per cycle while owning.
- Read return:
  - Registered tag {valid, who} is captured when mem_en & ~mem_we.
  - Next cycle, the tagged requester sees rvalid=1 and rdata=mem_rdata.
  - The other requester sees rvalid=0 and rdata=0.
  - A read return is delivered even if ownership switched in between.
- Transitions, evaluated at the rising edge:
  - IDLE, both requesting: go to the side not recorded in last_owner.
  - IDLE, one requesting: go to that side.
  - IDLE, none requesting: stay in IDLE.
  - OWN_X with lock_X=1: stay, regardless of req_X or the other side's wait.
  - OWN_X, lock_X=0, req_X=0: go to OWN_Y if req_Y, else IDLE.
  - OWN_X, lock_X=0, req_X=1, req_Y=1 and wait_cnt == MAX_WAIT-1: go to OWN_Y (pre-emption).
  - Any other case: stay.
  - A switch OWN_X to OWN_Y takes one edge with no idle bubble.
  - last_owner is updated on every entry to an OWN state.
- wait_cnt (8 bit):
  - Increments each cycle the port is owned and the non-owner has req=1.
  - Clears on any state change and whenever the non-owner's req=0.
  - Saturates at MAX_WAIT-1 while lock holds.
- Lock asserted while not owning has no effect. Lock only extends an existing ownership.
- Simultaneous events: a pre-emption decision and the current cycle's access by the outgoing owner both complete. The access is issued and the state changes at the same edge.
- Reset (asynchronous, mid-operation allowed):
  - state=IDLE, last_owner=HOST so the CPU wins the first tie.
  - wait_cnt=0, read tag cleared.
  - All gnt, rvalid, rdata and mem_* outputs are 0.
  - A pending read return is discarded.
- Requesters must hold req, addr, we and wdata stable until gnt is seen. The arbiter does not buffer requests.

Test Plan:
- Reset, then cpu_req=1 read at addr 0x10 with memory[0x10]=0x8A → cpu_gnt=1 one edge after the request. mem_en=1, mem_addr=0x10 in the granted cycle. Next cycle cpu_rvalid=1, cpu_rdata=0x8A, host_rvalid=0.
- cpu_req and host_req both rise in the same cycle from IDLE after reset → CPU granted first. After the CPU drops req, the host is granted the next edge with no IDLE cycle.
- CPU owns with continuous req, lock=0, host_req=1, MAX_WAIT=4 → host_gnt=1 after exactly 4 waiting cycles. The CPU's access in the last owned cycle still completes.
- Same as the previous scenario with cpu_lock=1 held for 10 cycles → host waits all 10 cycles. host_gnt rises one edge after the lock drops, provided host_req is still high.
- Host write 0x5C to 0x20, then CPU read of 0x20 → mem_we=1, mem_wdata=0x5C in the host cycle. CPU later receives cpu_rdata=0x5C.
- CPU read issued, then reset_n pulsed low before the return cycle → cpu_rvalid stays 0, all outputs are 0 during reset, and the state is IDLE on release.
